// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RX line, 3-sample majority vote per bit,
// optional even/odd parity, and one-cycle DATA_VALID / PAR_ERR / STP_ERR strobes.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d, rx_s_q, rx_s_d;
  logic [5:0]            edge_q, edge_d, presc_q, presc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  smp0_q, smp0_d, smp1_q, smp1_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, p_data_q, p_data_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  par_fail_q, par_fail_d;
  logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;

  logic       rx_s, maj, at_decide, at_end;
  logic [5:0] half;

  assign rx_s      = rx_s_q;
  assign half      = {1'b0, presc_q[5:1]};
  // Third sample is taken live in the decision cycle so the voted bit lands at P/2+2.
  assign maj       = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
  assign at_decide = (edge_q == half + 6'd1);
  assign at_end    = (edge_q == presc_q - 6'd1);

  always_comb begin
    state_d    = state_q;
    sync1_d    = RX_IN;
    rx_s_d     = sync1_q;
    edge_d     = edge_q;
    presc_d    = presc_q;
    bit_d      = bit_q;
    smp0_d     = smp0_q;
    smp1_d     = smp1_q;
    shreg_d    = shreg_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != IDLE) begin
      edge_d = at_end ? 6'd0 : edge_q + 6'd1;
      if (edge_q == half - 6'd1) smp0_d = rx_s;
      if (edge_q == half)        smp1_d = rx_s;
    end

    case (state_q)
      IDLE: begin
        edge_d = 6'd0;
        if (!rx_s) begin
          state_d    = START;
          edge_d     = 6'd1;
          presc_d    = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
          bit_d      = '0;
        end
      end
      START: begin
        if (at_decide && maj) begin
          state_d = IDLE;
          edge_d  = 6'd0;
        end else if (at_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_decide) shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
        if (at_end) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (at_decide && (maj != (^shreg_q ^ par_typ_q))) begin
          pe_d       = 1'b1;
          par_fail_d = 1'b1;
        end
        if (at_end) state_d = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not lost.
        if (at_decide) begin
          state_d = IDLE;
          edge_d  = 6'd0;
          if (!maj) begin
            se_d = 1'b1;
          end else if (!par_fail_q) begin
            dv_d     = 1'b1;
            p_data_d = shreg_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      edge_q     <= '0;
      presc_q    <= '0;
      bit_q      <= '0;
      smp0_q     <= 1'b0;
      smp1_q     <= 1'b0;
      shreg_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      edge_q     <= edge_d;
      presc_q    <= presc_d;
      bit_q      <= bit_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
      shreg_q    <= shreg_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, strobes logged with the
// cycle they appear in and compared against hand-computed T0-relative cycles.
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dv_c[$], dv_v[$], pe_c[$], se_c[$];

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (DATA_VALID) begin dv_c.push_back(cyc); dv_v.push_back(int'(P_DATA)); end
    if (PAR_ERR) pe_c.push_back(cyc);
    if (STP_ERR) se_c.push_back(cyc);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clr();
    dv_c.delete(); dv_v.delete(); pe_c.delete(); se_c.delete();
  endtask

  // nb = frame bit index (0 = start) that gets a one-cycle flip at offset P/2; -1 = none.
  task automatic send(input logic [7:0] d, input bit par, input logic pbit,
                      input logic sbit, input int nb);
    logic seq [0:10];
    int n, p;
    p = int'(Prescale);
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[i+1] = d[i];
    n = 9;
    if (par) begin seq[n] = pbit; n++; end
    seq[n] = sbit; n++;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < p; j++) begin
        RX_IN = (k == nb && j == p/2) ? ~seq[k] : seq[k];
        tick();
      end
  endtask

  int c;

  initial begin
    tick(); tick();
    chk("rst_pdata", int'(P_DATA), 0);
    chk("rst_dv", int'(DATA_VALID), 0);
    chk("rst_pe", int'(PAR_ERR), 0);
    chk("rst_se", int'(STP_ERR), 0);
    RST = 1'b1;
    idle(5);

    // P=8, no parity, 0xA5
    clr(); Prescale = 6'd8; PAR_EN = 0; c = cyc;
    send(8'hA5, 0, 0, 1, -1); idle(16);
    chk("a5_dv_n", dv_c.size(), 1);
    chk("a5_dv_cyc", qat(dv_c, 0) - c, 80);
    chk("a5_data", qat(dv_v, 0), 'hA5);
    chk("a5_err", pe_c.size() + se_c.size(), 0);

    // P=16, even parity, 0x3C good parity 0
    clr(); Prescale = 6'd16; PAR_EN = 1; PAR_TYP = 0; c = cyc;
    send(8'h3C, 1, 0, 1, -1); idle(32);
    chk("3c_dv_cyc", qat(dv_c, 0) - c, 172);
    chk("3c_data", int'(P_DATA), 'h3C);
    chk("3c_pe_n", pe_c.size(), 0);

    // same frame, bad parity 1
    clr(); c = cyc;
    send(8'h3C, 1, 1, 1, -1); idle(32);
    chk("3cbad_pe_n", pe_c.size(), 1);
    chk("3cbad_pe_cyc", qat(pe_c, 0) - c, 156);
    chk("3cbad_dv_n", dv_c.size(), 0);
    chk("3cbad_data", int'(P_DATA), 'h3C);

    // P=32, odd parity, 0xFF, stop driven low
    clr(); Prescale = 6'd32; PAR_EN = 1; PAR_TYP = 1; c = cyc;
    send(8'hFF, 1, 1, 0, -1); idle(64);
    chk("ff_se_n", se_c.size(), 1);
    chk("ff_se_cyc", qat(se_c, 0) - c, 340);
    chk("ff_dv_n", dv_c.size(), 0);
    chk("ff_pe_n", pe_c.size(), 0);

    // start glitch, then 0x5A
    clr(); Prescale = 6'd8; PAR_EN = 0; PAR_TYP = 0;
    RX_IN = 0; tick(); tick(); idle(20);
    chk("glitch_strobes", dv_c.size() + pe_c.size() + se_c.size(), 0);
    c = cyc;
    send(8'h5A, 0, 0, 1, -1); idle(16);
    chk("5a_dv_cyc", qat(dv_c, 0) - c, 80);
    chk("5a_data", qat(dv_v, 0), 'h5A);

    // back-to-back 0x01, 0x80
    clr(); c = cyc;
    send(8'h01, 0, 0, 1, -1);
    send(8'h80, 0, 0, 1, -1); idle(16);
    chk("b2b_dv_n", dv_c.size(), 2);
    chk("b2b_first_cyc", qat(dv_c, 0) - c, 80);
    chk("b2b_gap", qat(dv_c, 1) - qat(dv_c, 0), 80);
    chk("b2b_d0", qat(dv_v, 0), 'h01);
    chk("b2b_d1", qat(dv_v, 1), 'h80);

    // noise on the middle sample of data bit 2 of 0xC3
    clr(); c = cyc;
    send(8'hC3, 0, 0, 1, 3); idle(16);
    chk("noise_dv_cyc", qat(dv_c, 0) - c, 80);
    chk("noise_data", qat(dv_v, 0), 'hC3);

    // reset mid-DATA, then 0x77
    clr();
    RX_IN = 0; repeat (8) tick();
    RX_IN = 1; repeat (11) tick();
    RST = 0; tick();
    chk("mrst_pdata", int'(P_DATA), 0);
    chk("mrst_strobes", int'({DATA_VALID, PAR_ERR, STP_ERR}), 0);
    tick(); RST = 1; idle(10);
    chk("mrst_no_dv", dv_c.size(), 0);
    c = cyc;
    send(8'h77, 0, 0, 1, -1); idle(16);
    chk("77_dv_cyc", qat(dv_c, 0) - c, 80);
    chk("77_data", qat(dv_v, 0), 'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
